// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin selection among NUM_REQ
// requesters, one registered write per cycle toward the 5-to-32 decoder.
// Writes to address 0 are accepted but drop the write enable.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic                        i_stall,
  output logic                        o_wr_en,
  output logic [ADDR_W-1:0]           o_wr_addr,
  output logic [DATA_W-1:0]           o_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
  output logic                        o_conflict
);

  localparam int          ID_W = $clog2(NUM_REQ);
  localparam int unsigned N    = NUM_REQ;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              conflict_q, conflict_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              multi_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Round-robin search starting at rr_ptr; nothing is granted while stalled or in reset
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    if (i_rst_n && !i_stall) begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = 32'(rr_ptr_q) + i;
        if (idx >= N) idx = idx - N;
        if (!grant_found && i_req_valid[ID_W'(idx)]) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(idx);
        end
      end
    end
  end

  // Count valid requests to flag contention
  always_comb begin
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req_valid[i]) cnt = cnt + 1;
    end
    multi_valid = (cnt >= 2);
  end

  // One-hot ready and the granted requester's address/data
  always_comb begin
    o_req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
    sel_addr    = i_req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_data    = i_req_data[int'(grant_idx)*DATA_W +: DATA_W];
  end

  // Next-state: capture on transfer, otherwise hold payload and drop enable
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    conflict_d = multi_valid && !i_stall;
    if (grant_found) begin
      rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      wr_en_d    = (sel_addr != '0);
      wr_addr_d  = sel_addr;
      wr_data_d  = sel_data;
      grant_id_d = grant_idx;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
      conflict_q <= conflict_d;
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_grant_id = grant_id_q;
  assign o_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter (NUM_REQ=3, ADDR_W=5, DATA_W=32).
// A reference round-robin model predicts ready and the next-cycle outputs;
// predictions are queued at stimulus time and compared after the edge.
module tb_regfile_wr_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic [2:0]  i_req_valid;
  logic [14:0] i_req_addr;
  logic [95:0] i_req_data;
  logic [2:0]  o_req_ready;
  logic        i_stall;
  logic        o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic [1:0]  o_grant_id;
  logic        o_conflict;

  regfile_wr_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .i_stall     (i_stall),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_grant_id  (o_grant_id),
    .o_conflict  (o_conflict)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  id;
    logic        conf;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_rr   = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_id   = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
    i_req_valid[k]        = v;
    i_req_addr[k*5 +: 5]  = a;
    i_req_data[k*32 +: 32] = d;
  endtask

  // One cycle: predict & check ready mid-cycle, queue the expected outputs,
  // then compare them #1 after the rising edge.
  task automatic step();
    logic [2:0] exp_ready;
    int         g;
    int         nv;
    exp_t       e;
    exp_t       r;
    @(negedge i_clk);
    exp_ready = 3'b000;
    g  = -1;
    nv = 0;
    for (int i = 0; i < 3; i++) if (i_req_valid[i]) nv++;
    if (!i_stall) begin
      for (int i = 0; i < 3; i++) begin
        int k;
        k = (m_rr + i) % 3;
        if (g < 0 && i_req_valid[k]) g = k;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("ready", 64'(o_req_ready), 64'(exp_ready));
    e.en   = 1'b0;
    e.conf = (nv >= 2) && !i_stall;
    if (g >= 0) begin
      m_addr = i_req_addr[g*5 +: 5];
      m_data = i_req_data[g*32 +: 32];
      m_id   = 2'(g);
      e.en   = (m_addr != 5'd0);
      m_rr   = (g + 1) % 3;
    end
    e.addr = m_addr;
    e.data = m_data;
    e.id   = m_id;
    q.push_back(e);
    @(posedge i_clk);
    #1;
    r = q.pop_front();
    check("wr_en",    64'(o_wr_en),    64'(r.en));
    check("wr_addr",  64'(o_wr_addr),  64'(r.addr));
    check("wr_data",  64'(o_wr_data),  64'(r.data));
    check("grant_id", 64'(o_grant_id), 64'(r.id));
    check("conflict", 64'(o_conflict), 64'(r.conf));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_en"},    64'(o_wr_en),     64'd0);
    check({tag, "_addr"},  64'(o_wr_addr),   64'd0);
    check({tag, "_data"},  64'(o_wr_data),   64'd0);
    check({tag, "_id"},    64'(o_grant_id),  64'd0);
    check({tag, "_conf"},  64'(o_conflict),  64'd0);
    check({tag, "_ready"}, 64'(o_req_ready), 64'd0);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_stall     = 1'b0;
    i_req_valid = '0;
    i_req_addr  = '0;
    i_req_data  = '0;

    // reset: outputs zero, ready suppressed even with a request pending
    set_req(0, 1'b1, 5'd7, 32'h1111_1111);
    #1;
    check_zero_outputs("rst");
    @(posedge i_clk);
    #1;
    check_zero_outputs("rst_edge");
    set_req(0, 1'b0, 5'd0, 32'h0);
    i_rst_n = 1'b1;

    // single write from requester 0
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    step();

    // x0 write from requester 1: accepted, enable dropped
    set_req(1, 1'b1, 5'd0, 32'h0000_1234);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    step();

    // requester 2 held off by stall for 3 cycles, then granted
    set_req(2, 1'b1, 5'd9, 32'hCAFE_0002);
    i_stall = 1'b1;
    repeat (3) step();
    i_stall = 1'b0;
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    step();

    // all three continuously valid: rotation 0,1,2,0,1,2 with conflict
    set_req(0, 1'b1, 5'd1, 32'hA000_0000);
    set_req(1, 1'b1, 5'd2, 32'hB000_0001);
    set_req(2, 1'b1, 5'd3, 32'hC000_0002);
    repeat (6) step();
    i_req_valid = '0;
    step();

    // randomized traffic
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < 3; k++) begin
        logic [4:0] a;
        a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        set_req(k, 1'($urandom), a, $urandom);
      end
      i_stall = ($urandom_range(0, 3) == 0);
      step();
    end
    i_stall = 1'b0;

    // short mid-cycle reset pulse with traffic pending
    set_req(0, 1'b1, 5'd4, 32'h4444_4444);
    set_req(1, 1'b1, 5'd6, 32'h6666_6666);
    set_req(2, 1'b1, 5'd8, 32'h8888_8888);
    step();
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    i_rst_n = 1'b0;
    #1;
    check_zero_outputs("pulse");
    #2;
    i_rst_n = 1'b1;
    m_rr   = 0;
    m_addr = '0;
    m_data = '0;
    m_id   = '0;
    q.delete();
    step();
    check("post_rst_id", 64'(o_grant_id), 64'd1);
    i_req_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of write-port requesters (range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 5: register address width, matching the 5-to-32 write-select decode.
REQ-003 SHALL have parameter DATA_W, default 32: write data width.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_req_valid, input, NUM_REQ: per-requester write request.
REQ-007 SHALL have port i_req_addr, input, NUM_REQ*ADDR_W: packed destination addresses; requester k uses slice [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port i_req_data, input, NUM_REQ*DATA_W: packed write data; requester k uses slice [k*DATA_W +: DATA_W].
REQ-009 SHALL have port o_req_ready, output, NUM_REQ: one-hot grant; a transfer occurs for requester k when i_req_valid[k] and o_req_ready[k] are both 1.
REQ-010 SHALL have port i_stall, input, 1: 1 blocks the write port this cycle.
REQ-011 SHALL have port o_wr_en, output, 1: registered write enable to the address decoder.
REQ-012 SHALL have port o_wr_addr, output, ADDR_W: registered write address to the decoder.
REQ-013 SHALL have port o_wr_data, output, DATA_W: registered write data.
REQ-014 SHALL have port o_grant_id, output, clog2(NUM_REQ): registered index of the last accepted requester.
REQ-015 SHALL have port o_conflict, output, 1: registered pulse, 1 for one cycle after a cycle in which 2 or more requests were valid and i_stall was 0.

Function
REQ-016 SHALL compute o_req_ready combinationally from i_req_valid, i_stall and an internal round-robin pointer rr_ptr; o_req_ready is all-zero when i_stall=1 or no request is valid.
REQ-017 SHALL grant the first valid requester found searching k = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ; at most one ready bit is set per cycle.
REQ-018 SHALL update rr_ptr to (granted k + 1) mod NUM_REQ on a transfer; with no transfer, rr_ptr holds.
REQ-019 SHALL, on a transfer, capture the granted address and data at the edge; the next cycle o_wr_addr and o_wr_data equal them and o_wr_en = 1 if the address is nonzero. Latency is exactly 1 cycle.
REQ-020 SHALL accept (ready=1) a request with address 0 but drive o_wr_en=0 for it. This is a discarded x0 write, and o_wr_addr/o_wr_data still update.
REQ-021 SHALL drive o_wr_en=0 in any cycle following a cycle without a transfer; o_wr_addr, o_wr_data and o_grant_id hold their previous values.
REQ-022 SHALL update o_grant_id to the granted index on every transfer, including x0 writes.
REQ-023 SHALL sustain one transfer per cycle with no bubble while requests remain valid and i_stall=0.
REQ-024 SHALL leave requesters responsible for holding valid, addr and data stable until the transfer; the block does not check this.
REQ-025 SHALL treat a request arriving in the same cycle as i_stall falling as eligible immediately.

Reset
REQ-026 SHALL, while i_rst_n=0, asynchronously force o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_grant_id=0, o_conflict=0 and rr_ptr=0; o_req_ready is all-zero during reset.
REQ-027 SHALL discard a request granted in the cycle reset asserts; no write appears after reset release.
REQ-028 SHALL allow the first grant in the first cycle after reset deasserts, searching from requester 0.

Verification
REQ-029 SHALL be verified with: after reset, req0 valid with addr=5, data=0xDEADBEEF, stall=0 -> ready[0]=1 that cycle; next cycle o_wr_en=1, o_wr_addr=5, o_wr_data=0xDEADBEEF, o_grant_id=0.
REQ-030 SHALL be verified with: all three requesters valid continuously for 6 cycles (NUM_REQ=3) -> grant order 0,1,2,0,1,2; o_wr_en=1 for 6 consecutive cycles; o_conflict=1 for each.
REQ-031 SHALL be verified with: req1 valid with addr=0, data=0x1234 -> ready[1]=1; next cycle o_wr_en=0, o_wr_addr=0, o_grant_id=1.
REQ-032 SHALL be verified with: req2 valid and stall=1 for 3 cycles, then stall=0 -> ready all-zero for 3 cycles and rr_ptr unchanged; grant to 2 on the 4th cycle; write visible on the 5th.
REQ-033 SHALL be verified with: i_rst_n pulsed low mid-stream for less than one clock period -> outputs go to 0 immediately; after release the first grant goes to the lowest-index valid requester.
